// File: rtl/game_stats.sv
`default_nettype none
// ============================================================================
//  Module      : game_stats
//  Description : Round statistics for the falling-line typing game. Tracks
//                elapsed play time (BCD mm:ss), score (BCD, saturating),
//                current and best combo, and the round state shown on the
//                display overlay.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_stats #(
    parameter int SCORE_MAX   = 999,
    parameter int TIME_LIMIT  = 0,
    parameter int BONUS_EVERY = 10
) (
    input  logic        clk,
    input  logic        clk_rst,
    input  logic        tick_1s,
    input  logic        start,
    input  logic        pause,
    input  logic        hit,
    input  logic        miss,
    input  logic        win,
    input  logic        lose,
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic [11:0] score_bcd,
    output logic [7:0]  combo,
    output logic [7:0]  best_combo,
    output logic        running,
    output logic        timeout,
    output logic        done
);

    // Time limit and score ceiling pre-split into BCD digits so the
    // datapath compares digit-wise without any binary conversion.
    localparam int          c_LIM_MIN       = TIME_LIMIT / 60;
    localparam int          c_LIM_SEC       = TIME_LIMIT % 60;
    localparam logic [15:0] c_LIMIT_BCD     = {4'(c_LIM_MIN / 10), 4'(c_LIM_MIN % 10),
                                               4'(c_LIM_SEC / 10), 4'(c_LIM_SEC % 10)};
    localparam logic [11:0] c_SCORE_MAX_BCD = {4'(SCORE_MAX / 100), 4'((SCORE_MAX / 10) % 10),
                                               4'(SCORE_MAX % 10)};
    // Divisor kept non-zero so the modulo is always legal; the bonus is
    // separately gated off when BONUS_EVERY is 0.
    localparam logic [31:0] c_BONUS_DIV     = (BONUS_EVERY == 0) ? 32'd1 : 32'(BONUS_EVERY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start_q;
    logic [7:0]  r_min;
    logic [7:0]  r_sec;
    logic [11:0] r_score;
    logic [7:0]  r_combo;
    logic [7:0]  r_best;
    logic        r_running;
    logic        r_timeout;
    logic        r_done;

    logic        w_start_rise;
    logic        w_clear;
    logic        w_process;
    logic        w_limit_hit;
    logic [7:0]  w_min_inc;
    logic [7:0]  w_sec_inc;
    logic [7:0]  w_combo_inc;
    logic        w_bonus;
    logic [1:0]  w_score_add;
    logic [12:0] w_score_sum;
    logic [11:0] w_score_nxt;
    logic [7:0]  w_combo_nxt;
    logic [7:0]  w_best_nxt;

    // Adds 0..2 to a 3-digit BCD value; bit 12 is the carry out of the
    // hundreds digit so a wrap past 999 is caught by the saturation check.
    function automatic logic [12:0] bcd3_add(input logic [11:0] v, input logic [1:0] inc);
        logic [4:0] d0;
        logic [4:0] d1;
        logic [4:0] d2;
        logic       c;
        d0 = {1'b0, v[3:0]} + {3'b000, inc};
        c  = (d0 > 5'd9);
        if (c) d0 = d0 - 5'd10;
        d1 = {1'b0, v[7:4]} + {4'b0000, c};
        c  = (d1 > 5'd9);
        if (c) d1 = d1 - 5'd10;
        d2 = {1'b0, v[11:8]} + {4'b0000, c};
        c  = (d2 > 5'd9);
        if (c) d2 = d2 - 5'd10;
        return {c, d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    assign w_start_rise = start & ~r_start_q;

    // BCD mm:ss increment with saturation at 99:59.
    always_comb begin
        w_min_inc = r_min;
        w_sec_inc = r_sec;
        if ((r_min == 8'h99) && (r_sec == 8'h59)) begin
            w_min_inc = r_min;
            w_sec_inc = r_sec;
        end else if (r_sec[3:0] != 4'd9) begin
            w_sec_inc[3:0] = r_sec[3:0] + 4'd1;
        end else begin
            w_sec_inc[3:0] = 4'd0;
            if (r_sec[7:4] != 4'd5) begin
                w_sec_inc[7:4] = r_sec[7:4] + 4'd1;
            end else begin
                w_sec_inc[7:4] = 4'd0;
                if (r_min[3:0] != 4'd9) begin
                    w_min_inc[3:0] = r_min[3:0] + 4'd1;
                end else begin
                    w_min_inc[3:0] = 4'd0;
                    w_min_inc[7:4] = r_min[7:4] + 4'd1;
                end
            end
        end
    end

    assign w_limit_hit = (TIME_LIMIT != 0) && tick_1s && ({w_min_inc, w_sec_inc} == c_LIMIT_BCD);

    // Score/combo update for the current hit/miss pair.
    always_comb begin
        w_combo_inc = (r_combo == 8'hFF) ? 8'hFF : (r_combo + 8'd1);
        w_bonus     = (BONUS_EVERY != 0) && (({24'd0, w_combo_inc} % c_BONUS_DIV) == 32'd0);
        w_score_add = 2'd0;
        w_combo_nxt = r_combo;
        if (hit && !miss) begin
            w_combo_nxt = w_combo_inc;
            w_score_add = w_bonus ? 2'd2 : 2'd1;
        end else if (miss) begin
            w_combo_nxt = 8'd0;
            w_score_add = hit ? 2'd1 : 2'd0;
        end
        w_score_sum = bcd3_add(r_score, w_score_add);
        w_score_nxt = (w_score_sum[12] || (w_score_sum[11:0] > c_SCORE_MAX_BCD))
                      ? c_SCORE_MAX_BCD : w_score_sum[11:0];
        w_best_nxt  = (w_combo_nxt > r_best) ? w_combo_nxt : r_best;
    end

    // Round state transitions; win/lose outrank pause, pause outranks events.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_process   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_rise) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (win || lose) begin
                    w_state_nxt = S_DONE;
                end else if (pause) begin
                    w_state_nxt = S_PAUSED;
                end else begin
                    w_process = 1'b1;
                    if (w_limit_hit) w_state_nxt = S_DONE;
                end
            end
            S_PAUSED: begin
                if (win || lose) begin
                    w_state_nxt = S_DONE;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, start edge history and registered status flags.
    always_ff @(posedge clk) begin
        if (clk_rst) begin
            r_state   <= S_IDLE;
            r_start_q <= start;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
            r_timeout <= w_process & w_limit_hit;
        end
    end

    // Round counters: cleared on a new round, advanced only while running.
    always_ff @(posedge clk) begin
        if (clk_rst || w_clear) begin
            r_min   <= 8'h00;
            r_sec   <= 8'h00;
            r_score <= 12'h000;
            r_combo <= 8'd0;
            r_best  <= 8'd0;
        end else if (w_process) begin
            if (tick_1s) begin
                r_min <= w_min_inc;
                r_sec <= w_sec_inc;
            end
            r_score <= w_score_nxt;
            r_combo <= w_combo_nxt;
            r_best  <= w_best_nxt;
        end
    end

    assign min_bcd    = r_min;
    assign sec_bcd    = r_sec;
    assign score_bcd  = r_score;
    assign combo      = r_combo;
    assign best_combo = r_best;
    assign running    = r_running;
    assign timeout    = r_timeout;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_game_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_stats
//  Description : Self-checking bench for game_stats. Two instances share the
//                stimulus: one with defaults, one with a 3 s limit, score
//                ceiling 20 and no combo bonus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_stats;

    // Stimulus bit masks: {rst, tick, start, pause, hit, miss, win, lose}
    localparam logic [7:0] c_RST = 8'h80;
    localparam logic [7:0] c_TCK = 8'h40;
    localparam logic [7:0] c_STR = 8'h20;
    localparam logic [7:0] c_PAU = 8'h10;
    localparam logic [7:0] c_HIT = 8'h08;
    localparam logic [7:0] c_MIS = 8'h04;
    localparam logic [7:0] c_LOS = 8'h01;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    typedef struct packed {
        logic rst, tick, start, pause, hit, miss, win, lose;
    } stim_t;

    typedef struct {
        int st; int secs; int score; int combo; int best; bit tmo; bit sq;
    } model_t;

    typedef struct packed {
        logic [7:0] mn; logic [7:0] sc; logic [11:0] score;
        logic [7:0] combo; logic [7:0] best; logic run; logic tmo; logic dn;
    } obs_t;

    typedef struct {
        logic [7:0] s; int reps;
        logic [7:0] mn; logic [7:0] sc; logic [11:0] score;
        logic [7:0] combo; logic [7:0] best; logic run; logic dn;
    } vec_t;

    logic clk, clk_rst, tick_1s, start, pause, hit, miss, win, lose;
    logic [7:0]  a_min, a_sec, a_combo, a_best, b_min, b_sec, b_combo, b_best;
    logic [11:0] a_score, b_score;
    logic        a_run, a_tmo, a_done, b_run, b_tmo, b_done;

    int n_tests = 0;
    int n_fail  = 0;
    model_t m_a, m_b;
    obs_t q_a[$];
    obs_t q_b[$];
    vec_t tbl[12];

    game_stats #(.SCORE_MAX(999), .TIME_LIMIT(0), .BONUS_EVERY(10)) dut_a (
        .clk(clk), .clk_rst(clk_rst), .tick_1s(tick_1s), .start(start), .pause(pause),
        .hit(hit), .miss(miss), .win(win), .lose(lose),
        .min_bcd(a_min), .sec_bcd(a_sec), .score_bcd(a_score), .combo(a_combo),
        .best_combo(a_best), .running(a_run), .timeout(a_tmo), .done(a_done));

    game_stats #(.SCORE_MAX(20), .TIME_LIMIT(3), .BONUS_EVERY(0)) dut_b (
        .clk(clk), .clk_rst(clk_rst), .tick_1s(tick_1s), .start(start), .pause(pause),
        .hit(hit), .miss(miss), .win(win), .lose(lose),
        .min_bcd(b_min), .sec_bcd(b_sec), .score_bcd(b_score), .combo(b_combo),
        .best_combo(b_best), .running(b_run), .timeout(b_tmo), .done(b_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time kept as total seconds, score as a plain integer.
    function automatic model_t mstep(input model_t m, input stim_t s,
                                     input int smax, input int tlim, input int bev);
        model_t n;
        bit     rise;
        int     inc;
        n     = m;
        n.tmo = 1'b0;
        n.sq  = s.start;
        if (s.rst) begin
            n.st = M_IDLE; n.secs = 0; n.score = 0; n.combo = 0; n.best = 0;
            return n;
        end
        rise = s.start && !m.sq;
        case (m.st)
            M_IDLE, M_DONE: begin
                if (rise) begin
                    n.st = M_RUN; n.secs = 0; n.score = 0; n.combo = 0; n.best = 0;
                end
            end
            M_RUN: begin
                if (s.win || s.lose) n.st = M_DONE;
                else if (s.pause) n.st = M_PAUSED;
                else begin
                    if (s.tick) begin
                        if (m.secs < 5999) n.secs = m.secs + 1;
                        if (tlim != 0 && n.secs == tlim) begin
                            n.tmo = 1'b1; n.st = M_DONE;
                        end
                    end
                    if (s.hit && !s.miss) begin
                        n.combo = (m.combo < 255) ? m.combo + 1 : 255;
                        inc = 1;
                        if (bev != 0) if (n.combo % bev == 0) inc = 2;
                        n.score = (m.score + inc > smax) ? smax : m.score + inc;
                        if (n.combo > m.best) n.best = n.combo;
                    end else if (s.miss) begin
                        n.combo = 0;
                        if (s.hit) n.score = (m.score + 1 > smax) ? smax : m.score + 1;
                    end
                end
            end
            M_PAUSED: begin
                if (s.win || s.lose) n.st = M_DONE;
                else if (!s.pause) n.st = M_RUN;
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic obs_t obs_of(input model_t m);
        obs_t o;
        int   mins, secs;
        mins    = m.secs / 60;
        secs    = m.secs % 60;
        o.mn    = {4'(mins / 10), 4'(mins % 10)};
        o.sc    = {4'(secs / 10), 4'(secs % 10)};
        o.score = {4'(m.score / 100), 4'((m.score / 10) % 10), 4'(m.score % 10)};
        o.combo = 8'(m.combo);
        o.best  = 8'(m.best);
        o.run   = (m.st == M_RUN);
        o.tmo   = m.tmo;
        o.dn    = (m.st == M_DONE);
        return o;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp);
        cmp({tag, ".min"},     32'(act.mn),    32'(exp.mn));
        cmp({tag, ".sec"},     32'(act.sc),    32'(exp.sc));
        cmp({tag, ".score"},   32'(act.score), 32'(exp.score));
        cmp({tag, ".combo"},   32'(act.combo), 32'(exp.combo));
        cmp({tag, ".best"},    32'(act.best),  32'(exp.best));
        cmp({tag, ".running"}, 32'(act.run),   32'(exp.run));
        cmp({tag, ".timeout"}, 32'(act.tmo),   32'(exp.tmo));
        cmp({tag, ".done"},    32'(act.dn),    32'(exp.dn));
    endtask

    // Drive one cycle, push model predictions, then pop and compare both DUTs.
    task automatic step(input logic [7:0] bits);
        stim_t s;
        obs_t  ea, eb;
        s = stim_t'(bits);
        @(negedge clk);
        {clk_rst, tick_1s, start, pause, hit, miss, win, lose} = bits;
        m_a = mstep(m_a, s, 999, 0, 10);
        m_b = mstep(m_b, s, 20, 3, 0);
        q_a.push_back(obs_of(m_a));
        q_b.push_back(obs_of(m_b));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp_obs("a", {a_min, a_sec, a_score, a_combo, a_best, a_run, a_tmo, a_done}, ea);
        cmp_obs("b", {b_min, b_sec, b_score, b_combo, b_best, b_run, b_tmo, b_done}, eb);
    endtask

    initial begin
        {clk_rst, tick_1s, start, pause, hit, miss, win, lose} = 8'h00;
        m_a = '{M_IDLE, 0, 0, 0, 0, 1'b0, 1'b0};
        m_b = '{M_IDLE, 0, 0, 0, 0, 1'b0, 1'b0};

        //          stim                    reps  min    sec    score    combo  best   run   done
        tbl[0]  = '{c_RST,                    2, 8'h00, 8'h00, 12'h000, 8'd0,  8'd0,  1'b0, 1'b0};
        tbl[1]  = '{c_STR,                    1, 8'h00, 8'h00, 12'h000, 8'd0,  8'd0,  1'b1, 1'b0};
        tbl[2]  = '{c_STR|c_TCK,             61, 8'h01, 8'h01, 12'h000, 8'd0,  8'd0,  1'b1, 1'b0};
        tbl[3]  = '{c_STR|c_HIT,             12, 8'h01, 8'h01, 12'h013, 8'd12, 8'd12, 1'b1, 1'b0};
        tbl[4]  = '{c_STR|c_MIS,              1, 8'h01, 8'h01, 12'h013, 8'd0,  8'd12, 1'b1, 1'b0};
        tbl[5]  = '{c_STR|c_HIT,              3, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b1, 1'b0};
        tbl[6]  = '{c_STR|c_PAU|c_TCK|c_HIT,  3, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b0, 1'b0};
        tbl[7]  = '{c_STR|c_PAU|c_TCK,        2, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b0, 1'b0};
        tbl[8]  = '{c_STR,                    1, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b1, 1'b0};
        tbl[9]  = '{c_STR|c_LOS|c_HIT,        1, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b0, 1'b1};
        tbl[10] = '{8'h00,                    1, 8'h01, 8'h01, 12'h016, 8'd3,  8'd12, 1'b0, 1'b1};
        tbl[11] = '{c_STR,                    1, 8'h00, 8'h00, 12'h000, 8'd0,  8'd0,  1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].s);
            cmp($sformatf("vec%0d.min", i),     32'(a_min),   32'(tbl[i].mn));
            cmp($sformatf("vec%0d.sec", i),     32'(a_sec),   32'(tbl[i].sc));
            cmp($sformatf("vec%0d.score", i),   32'(a_score), 32'(tbl[i].score));
            cmp($sformatf("vec%0d.combo", i),   32'(a_combo), 32'(tbl[i].combo));
            cmp($sformatf("vec%0d.best", i),    32'(a_best),  32'(tbl[i].best));
            cmp($sformatf("vec%0d.running", i), 32'(a_run),   32'(tbl[i].run));
            cmp($sformatf("vec%0d.done", i),    32'(a_done),  32'(tbl[i].dn));
        end

        // Score ceiling 20 without bonus, then the 3 s limit on the same round.
        step(c_RST);
        step(c_STR);
        repeat (25) step(c_STR|c_HIT);
        cmp("sat.score", 32'(b_score), 32'h020);
        cmp("sat.combo", 32'(b_combo), 32'd25);
        cmp("sat.best",  32'(b_best),  32'd25);
        repeat (2) step(c_STR|c_TCK);
        cmp("lim.tick2.timeout", 32'(b_tmo), 32'd0);
        cmp("lim.tick2.sec",     32'(b_sec), 32'h02);
        step(c_STR|c_TCK);
        cmp("lim.tick3.timeout", 32'(b_tmo),  32'd1);
        cmp("lim.tick3.done",    32'(b_done), 32'd1);
        cmp("lim.tick3.sec",     32'(b_sec),  32'h03);
        step(c_STR|c_TCK);
        cmp("lim.tick4.timeout", 32'(b_tmo),  32'd0);
        cmp("lim.tick4.done",    32'(b_done), 32'd1);
        cmp("lim.tick4.sec",     32'(b_sec),  32'h03);

        // Reset mid-round with start held high must not restart the round.
        step(c_STR|c_HIT|c_RST);
        cmp("midrst.score",   32'(a_score), 32'h000);
        cmp("midrst.running", 32'(a_run),   32'd0);
        step(c_STR);
        cmp("midrst.norestart", 32'(a_run), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_stats.md
Name: game_stats

Overview:
- Downstream consumer of the falling-line engine's gameplay events (hit, miss, win, lose, start) and the game's 1 s timebase.
- Maintains elapsed play time, score and combo for the round.
- Produces BCD digits for the seven-segment decoders (mh/ml, hh/hl) and status flags for the VGA overlay select.
- Sits between the game core and the display path; owns no video timing.

Parameters:
- SCORE_MAX, 999, score saturation value; must be ≤999 so the score fits 3 BCD digits.
- TIME_LIMIT, 0, round limit in seconds; 0 = no limit; otherwise 1..5999.
- BONUS_EVERY, 10, every BONUS_EVERY-th consecutive hit adds 1 extra point; 0 disables the bonus.

Ports:
- clk  in  1  system clock, 50 MHz
- clk_rst  in  1  synchronous reset, active-high
- tick_1s  in  1  one-clk-wide pulse per second, already in the clk domain
- start  in  1  level from the start screen; a rising edge begins a round
- pause  in  1  level; high freezes the timer and ignores hit/miss
- hit  in  1  one-clk pulse on each correctly typed character
- miss  in  1  one-clk pulse on each character reaching the floor or on a wrong key
- win  in  1  level from the game core
- lose  in  1  level from the game core
- min_bcd  out  8  elapsed minutes, {tens,ones}
- sec_bcd  out  8  elapsed seconds, {tens,ones}, 00..59
- score_bcd  out  12  score, {hundreds,tens,ones}
- combo  out  8  current consecutive-hit count
- best_combo  out  8  maximum combo reached this round
- running  out  1  high in state RUN
- timeout  out  1  one-clk pulse when TIME_LIMIT is reached
- done  out  1  high in state DONE

Behaviour:
- Reset (clk_rst=1 at a clk edge) values:
  - All counters 0.
  - State IDLE.
  - running=0, timeout=0, done=0.
  - The start edge register is loaded with the current start value, so a start held high through reset does not fire.
- start_rise = start & ~start_q, where start_q is registered every cycle.
- States:
  - IDLE: counters hold. On start_rise, clear all counters and go to RUN on the next cycle.
  - RUN:
    - If win|lose, go to DONE. This has highest priority and the same cycle's hit/miss/tick is ignored.
    - Else if pause, go to PAUSED; hit/miss/tick in that cycle are ignored.
    - Else process the events below.
  - PAUSED: everything frozen. When pause=0, return to RUN; win|lose has priority and goes to DONE.
  - DONE: all outputs frozen at their final values. On start_rise, clear counters and go to RUN. This is the only exit other than reset.
- Timer, RUN only, on tick_1s:
  - Seconds count 00..59; 59 wraps to 00 and carries into minutes.
  - Minutes count to 99:59 and then saturate; a later tick holds the value.
  - All arithmetic is BCD digit-wise; no binary-to-BCD conversion.
  - If TIME_LIMIT≠0 and the post-increment elapsed time equals TIME_LIMIT seconds:
    - timeout pulses for 1 cycle, in the cycle after the tick.
    - State goes to DONE.
    - The displayed time equals the limit.
- Score and combo, RUN only:
  - hit&~miss:
    - combo+1, saturating at 255.
    - score+1.
    - If BONUS_EVERY≠0 and the new combo is a multiple of BONUS_EVERY, score+2 in total instead of +1.
  - miss (with or without hit):
    - combo cleared to 0.
    - If hit is also present, score+1 with no bonus check.
  - Score saturates at SCORE_MAX; an increment that would exceed it sets the score to SCORE_MAX.
  - best_combo = max(best_combo, new combo), updated in the same cycle as combo.
- hit and tick_1s in the same cycle are both applied.
- Latency:
  - All outputs are registered.
  - An event at edge N is visible at outputs after edge N+1.
- Reset mid-round: returns to IDLE with zeroed outputs on the next edge, regardless of the other inputs.

Test Plan:
- Reset, start 0→1, then 61 tick_1s pulses → min_bcd=8'h01, sec_bcd=8'h01, running=1, done=0.
- TIME_LIMIT=0, 12 hits then 1 miss then 3 hits → combo=3, best_combo=12, score_bcd=12'h016 (12+1 bonus at hit 10, then +3).
- pause=1 for 5 ticks and 3 hits, then pause=0 → time and score unchanged; running=0 during pause, 1 after.
- SCORE_MAX=20, 25 hits with BONUS_EVERY=0 → score_bcd=12'h020, combo=25.
- TIME_LIMIT=3, start, then 4 ticks → timeout high for exactly 1 cycle after the 3rd tick; done=1; sec_bcd=8'h03 holds after the 4th tick.
- lose=1 in the same cycle as hit → score unchanged, done=1 next cycle; start held high, then 0→1 again → counters cleared, running=1.
